// File: rtl/csr_trap_seq.sv
// csr_trap_seq: sequences Zicsr, ECALL, MRET and illegal-instruction traps
// onto the single-ported machine-mode CSR file.
module csr_trap_seq #(
    parameter int XLEN          = 32,
    parameter int CAUSE_ECALL   = 11,
    parameter int CAUSE_ILLEGAL = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [11:0]     req_csr,
    input  logic [XLEN-1:0] req_src,
    input  logic            req_nowrite,
    input  logic [XLEN-1:0] req_pc,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            csr_wen,
    output logic [XLEN-1:0] csr_addr,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            busy
);
    localparam logic [11:0] MSTATUS = 12'h300;
    localparam logic [11:0] MTVEC   = 12'h305;
    localparam logic [11:0] MEPC    = 12'h341;
    localparam logic [11:0] MCAUSE  = 12'h342;
    localparam logic [2:0] OP_RW = 3'd0, OP_RS = 3'd1, OP_ECALL = 3'd3, OP_MRET = 3'd4, OP_ILL = 3'd5;

    typedef enum logic [3:0] {IDLE, ZRD, ZWR, TEPC, TCAUSE, SRD, SWR, TVEC, REPC} state_t;

    state_t          state, nxt;
    logic [2:0]      op, op_n;
    logic [11:0]     csr, addr;
    logic [XLEN-1:0] src, pc, old, ms_trap, ms_mret;
    logic            nowrite, csr_ok;

    // Bad CSR addresses and reserved opcodes collapse into the illegal trap at accept.
    assign csr_ok = req_csr inside {MSTATUS, MTVEC, MEPC, MCAUSE};
    assign op_n   = (req_op > OP_ILL || (req_op < OP_ECALL && !csr_ok)) ? OP_ILL : req_op;
    assign req_ready = state == IDLE;
    assign busy      = !req_ready;
    assign csr_addr  = XLEN'(addr);

    always_comb begin
        ms_trap        = old;
        ms_trap[7]     = old[3];
        ms_trap[3]     = 1'b0;
        ms_trap[12:11] = 2'b11;
        ms_mret        = old;
        ms_mret[3]     = old[7];
        ms_mret[7]     = 1'b1;
        ms_mret[12:11] = 2'b11;
    end

    always_comb begin
        nxt            = state;
        addr           = 12'h0;
        csr_wen        = 1'b0;
        csr_wdata      = '0;
        resp_valid     = 1'b0;
        resp_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            IDLE: if (req_valid) nxt = op_n < OP_ECALL ? ZRD : op_n == OP_MRET ? SRD : TEPC;
            ZRD: begin
                addr = csr;
                nxt  = ZWR;
            end
            ZWR: begin
                addr       = csr;
                csr_wen    = op == OP_RW || !nowrite;
                csr_wdata  = op == OP_RW ? src : op == OP_RS ? old | src : old & ~src;
                resp_valid = 1'b1;
                resp_rdata = old;
                nxt        = IDLE;
            end
            TEPC: begin
                addr      = MEPC;
                csr_wen   = 1'b1;
                csr_wdata = pc;
                nxt       = TCAUSE;
            end
            TCAUSE: begin
                addr      = MCAUSE;
                csr_wen   = 1'b1;
                csr_wdata = op == OP_ECALL ? XLEN'(CAUSE_ECALL) : XLEN'(CAUSE_ILLEGAL);
                nxt       = SRD;
            end
            SRD: begin
                addr = MSTATUS;
                nxt  = SWR;
            end
            SWR: begin
                addr      = MSTATUS;
                csr_wen   = 1'b1;
                csr_wdata = op == OP_MRET ? ms_mret : ms_trap;
                nxt       = op == OP_MRET ? REPC : TVEC;
            end
            TVEC: begin
                addr           = MTVEC;
                resp_valid     = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = {csr_rdata[XLEN-1:2], 2'b00};
                nxt            = IDLE;
            end
            REPC: begin
                addr           = MEPC;
                resp_valid     = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = csr_rdata;
                nxt            = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op      <= '0;
            csr     <= '0;
            src     <= '0;
            nowrite <= 1'b0;
            pc      <= '0;
            old     <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && req_valid) begin
                op      <= op_n;
                csr     <= req_csr;
                src     <= req_src;
                nowrite <= req_nowrite;
                pc      <= req_pc;
            end
            if (state == ZRD || state == SRD) old <= csr_rdata;
        end
    end
endmodule
